instr_fetch_unit: RTL and testbench

- Fetch stage directly upstream of the control unit in the 16-bit MSP430-style core.
- Owns the PC and reads instruction words from program memory over a ready handshake.
- Presents each word plus a valid flag to the control unit; the control unit consumes it with instr_ack.
- On a jump, evaluates the condition against ALU flags and redirects the PC by 2*sext(offset).

---
 rtl/cpu_pkg.sv | 25 ++
 rtl/branch_cond_eval.sv | 28 ++
 rtl/instr_fetch_unit.sv | 110 +++++++++++
 tb/tb_instr_fetch_unit.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit core: word width, PC step,
// jump condition codes and fetch-stage state encodings.
package cpu_pkg;

    localparam int          WORD_W  = 16;
    localparam logic [15:0] PC_STEP = 16'd2;

    typedef enum logic [2:0] {
        JNE = 3'b000,
        JEQ = 3'b001,
        JNC = 3'b010,
        JC  = 3'b011,
        JN  = 3'b100,
        JGE = 3'b101,
        JL  = 3'b110,
        JMP = 3'b111
    } jp_cond_e;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_HOLD = 2'd1,
        S_ERR  = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational jump-condition evaluator: condition code plus ALU flags -> taken.
module branch_cond_eval
    import cpu_pkg::*;
(
    input  logic [2:0] jp_cond,
    input  logic       flag_n,
    input  logic       flag_z,
    input  logic       flag_c,
    input  logic       flag_v,
    output logic       taken
);

    always_comb begin
        taken = 1'b0;
        case (jp_cond_e'(jp_cond))
            JNE:     taken = !flag_z;
            JEQ:     taken = flag_z;
            JNC:     taken = !flag_c;
            JC:      taken = flag_c;
            JN:      taken = flag_n;
            JGE:     taken = !(flag_n ^ flag_v);
            JL:      taken = flag_n ^ flag_v;
            JMP:     taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, reads program memory over a ready handshake,
// holds each word until the control unit acks it, and applies jump redirects.
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter int          MEM_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    output logic [WORD_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [WORD_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [WORD_W-1:0] instr,
    output logic              instr_valid,
    input  logic              instr_ack,
    input  logic              halt,
    input  logic              branch_en,
    input  logic [2:0]        jp_cond,
    input  logic [9:0]        pc_offset,
    input  logic              flag_n,
    input  logic              flag_z,
    input  logic              flag_c,
    input  logic              flag_v,
    output logic [WORD_W-1:0] pc,
    output logic              branch_taken,
    output logic              fetch_err
);

    localparam logic [7:0] TMO = MEM_TIMEOUT[7:0];

    fetch_state_e      state, state_nx;
    logic [7:0]        wait_cnt;
    logic              cond_taken;
    logic              fetch_done;
    logic              wait_cyc;
    logic              wait_hit;
    logic              ack_ev;
    logic              redirect;
    logic [WORD_W-1:0] br_disp;

    branch_cond_eval u_cond (
        .jp_cond (jp_cond),
        .flag_n  (flag_n),
        .flag_z  (flag_z),
        .flag_c  (flag_c),
        .flag_v  (flag_v),
        .taken   (cond_taken)
    );

    assign fetch_done = mem_rd && mem_ready;
    assign wait_cyc   = mem_rd && !mem_ready;
    assign wait_hit   = wait_cyc && ((wait_cnt + 8'd1) == TMO);
    assign ack_ev     = (state == S_HOLD) && instr_ack;
    assign redirect   = ack_ev && branch_en && cond_taken;
    // Word offset scaled to bytes; pc already points past the jump word.
    assign br_disp    = {{5{pc_offset[9]}}, pc_offset, 1'b0};
    assign mem_addr   = pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_REQ;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_REQ: begin
                if (fetch_done)    state_nx = S_HOLD;
                else if (wait_hit) state_nx = S_ERR;
            end
            S_HOLD:  if (instr_ack) state_nx = S_REQ;
            S_ERR:   state_nx = S_ERR;
            default: state_nx = S_REQ;
        endcase
    end

    // Gated by rst so an in-flight request drops the moment reset asserts.
    always_comb begin
        mem_rd = (state == S_REQ) && !halt && !rst;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc           <= RESET_PC;
            instr        <= '0;
            instr_valid  <= 1'b0;
            branch_taken <= 1'b0;
            fetch_err    <= 1'b0;
            wait_cnt     <= '0;
        end else begin
            branch_taken <= redirect;
            if (fetch_done) begin
                instr       <= mem_rdata;
                instr_valid <= 1'b1;
                pc          <= pc + PC_STEP;
                wait_cnt    <= '0;
            end else if (wait_cyc) begin
                wait_cnt <= wait_cnt + 8'd1;
                if (wait_hit) fetch_err <= 1'b1;
            end
            if (ack_ev) begin
                instr_valid <= 1'b0;
                if (redirect) pc <= pc + br_disp;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench: default instance for fetch/hold/branch, second instance
// (RESET_PC=FFFE, MEM_TIMEOUT=3) for wrap, halt freeze and timeout.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] mem_rdata;
    logic        mem_ready, instr_ack, halt, branch_en;
    logic [2:0]  jp_cond;
    logic [9:0]  pc_offset;
    logic        flag_n, flag_z, flag_c, flag_v;

    logic [15:0] mem_addr, instr, pc;
    logic        mem_rd, instr_valid, branch_taken, fetch_err;
    logic [15:0] mem_addr_w, instr_w, pc_w;
    logic        mem_rd_w, instr_valid_w, branch_taken_w, fetch_err_w;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    instr_fetch_unit dut (
        .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_rd(mem_rd),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .instr(instr),
        .instr_valid(instr_valid), .instr_ack(instr_ack), .halt(halt),
        .branch_en(branch_en), .jp_cond(jp_cond), .pc_offset(pc_offset),
        .flag_n(flag_n), .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v),
        .pc(pc), .branch_taken(branch_taken), .fetch_err(fetch_err)
    );

    instr_fetch_unit #(.RESET_PC(16'hFFFE), .MEM_TIMEOUT(3)) dut_w (
        .clk(clk), .rst(rst), .mem_addr(mem_addr_w), .mem_rd(mem_rd_w),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .instr(instr_w),
        .instr_valid(instr_valid_w), .instr_ack(instr_ack), .halt(halt),
        .branch_en(branch_en), .jp_cond(jp_cond), .pc_offset(pc_offset),
        .flag_n(flag_n), .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v),
        .pc(pc_w), .branch_taken(branch_taken_w), .fetch_err(fetch_err_w)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        tick();
        rst = 1'b0;
    endtask

    // Memory answers in the current cycle; word visible after the edge.
    task automatic fetch(input logic [15:0] data);
        mem_rdata = data;
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
    endtask

    task automatic ack(input logic br, input logic [2:0] cond, input logic [9:0] off);
        instr_ack = 1'b1;
        branch_en = br;
        jp_cond   = cond;
        pc_offset = off;
        tick();
        instr_ack = 1'b0;
        branch_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1; mem_rdata = '0; mem_ready = 1'b0; instr_ack = 1'b0;
        halt = 1'b0; branch_en = 1'b0; jp_cond = 3'b000; pc_offset = '0;
        flag_n = 1'b0; flag_z = 1'b0; flag_c = 1'b0; flag_v = 1'b0;
        #2;
        chk("rst_pc", pc, 16'h0000);
        chk("rst_valid", {15'd0, instr_valid}, 16'd0);
        chk("rst_instr", instr, 16'h0000);
        chk("rst_mem_rd", {15'd0, mem_rd}, 16'd0);
        chk("rst_err", {15'd0, fetch_err}, 16'd0);
        chk("rst_pc_w", pc_w, 16'hFFFE);

        // First fetch
        tick();
        rst = 1'b0;
        mem_rdata = 16'h4504;
        mem_ready = 1'b1;
        #1;
        chk("f1_addr", mem_addr, 16'h0000);
        chk("f1_rd", {15'd0, mem_rd}, 16'd1);
        tick();
        mem_ready = 1'b0;
        chk("f1_instr", instr, 16'h4504);
        chk("f1_valid", {15'd0, instr_valid}, 16'd1);
        chk("f1_pc", pc, 16'h0002);

        // Hold without ack
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_instr", instr, 16'h4504);
            chk("hold_valid", {15'd0, instr_valid}, 16'd1);
            chk("hold_rd", {15'd0, mem_rd}, 16'd0);
        end
        ack(1'b0, 3'b000, 10'h000);
        chk("ack_valid", {15'd0, instr_valid}, 16'd0);
        chk("ack_addr", mem_addr, 16'h0002);
        chk("ack_rd", {15'd0, mem_rd}, 16'd1);

        // Advance to pc=0010 in S_HOLD
        for (int i = 0; i < 6; i++) begin
            fetch(16'h1000 + 16'(i));
            ack(1'b0, 3'b000, 10'h000);
        end
        fetch(16'h2400);
        chk("pre_jeq_pc", pc, 16'h0010);

        // branch_en without ack is ignored
        branch_en = 1'b1; jp_cond = 3'b111; pc_offset = 10'h005;
        tick();
        branch_en = 1'b0;
        chk("noack_pc", pc, 16'h0010);
        chk("noack_bt", {15'd0, branch_taken}, 16'd0);

        // Taken JEQ backward
        flag_z = 1'b1;
        ack(1'b1, 3'b001, 10'h3FC);
        chk("jeq_pc", pc, 16'h0008);
        chk("jeq_bt", {15'd0, branch_taken}, 16'd1);
        flag_z = 1'b0;
        tick();
        chk("jeq_bt_pulse", {15'd0, branch_taken}, 16'd0);

        // Not-taken JGE (N=1,V=0)
        fetch(16'h3401);
        chk("jge_pre_pc", pc, 16'h000A);
        flag_n = 1'b1; flag_v = 1'b0;
        ack(1'b1, 3'b101, 10'h005);
        chk("jge_pc", pc, 16'h000A);
        chk("jge_bt", {15'd0, branch_taken}, 16'd0);

        // JMP +5 words
        fetch(16'h3C05);
        ack(1'b1, 3'b111, 10'h005);
        chk("jmp_pc", pc, 16'h0016);
        chk("jmp_bt", {15'd0, branch_taken}, 16'd1);
        flag_n = 1'b0;

        // Ack outside S_HOLD with halt: no request, no redirect
        halt = 1'b1;
        ack(1'b1, 3'b111, 10'h005);
        chk("halt_rd", {15'd0, mem_rd}, 16'd0);
        chk("halt_ack_pc", pc, 16'h0016);
        chk("halt_ack_bt", {15'd0, branch_taken}, 16'd0);
        halt = 1'b0;

        // Wrap on second instance
        do_reset();
        fetch(16'h4303);
        chk("wrap_pc", pc_w, 16'h0000);
        ack(1'b0, 3'b000, 10'h000);
        fetch(16'h3FFF);
        chk("wrap2_pc", pc_w, 16'h0002);
        ack(1'b1, 3'b111, 10'h3FF);
        chk("wrap_jmp_pc", pc_w, 16'h0000);
        chk("wrap_jmp_bt", {15'd0, branch_taken_w}, 16'd1);

        // Halt mid-wait freezes the counter (timeout 3)
        do_reset();
        tick();
        tick();
        chk("frz_err0", {15'd0, fetch_err_w}, 16'd0);
        halt = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("frz_rd", {15'd0, mem_rd_w}, 16'd0);
        chk("frz_err1", {15'd0, fetch_err_w}, 16'd0);
        halt = 1'b0;
        tick();
        chk("frz_err2", {15'd0, fetch_err_w}, 16'd1);

        // Timeout after exactly 3 wait cycles, sticky, cleared by rst
        do_reset();
        tick();
        tick();
        chk("tmo_err_early", {15'd0, fetch_err_w}, 16'd0);
        chk("tmo_rd_early", {15'd0, mem_rd_w}, 16'd1);
        tick();
        chk("tmo_err", {15'd0, fetch_err_w}, 16'd1);
        chk("tmo_rd", {15'd0, mem_rd_w}, 16'd0);
        mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        mem_ready = 1'b0;
        chk("tmo_sticky", {15'd0, fetch_err_w}, 16'd1);
        chk("tmo_valid", {15'd0, instr_valid_w}, 16'd0);
        rst = 1'b1;
        #1;
        chk("tmo_rst_err", {15'd0, fetch_err_w}, 16'd0);
        chk("tmo_rst_pc", pc_w, 16'hFFFE);
        tick();
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
